// File: rtl/cache_unit.sv
// cache_unit: direct-mapped, read-only lookup cache in front of a one-cycle-latency main memory.
// Optional hit/miss counters are compiled in when the macro CACHE_STATS_EN is defined.
module cache_unit #(
  parameter int NUM_LINES     = 1024,
  parameter int PRELOAD_LINES = 512,
  parameter int DATA_W        = 64,
  parameter int TAG_W         = 28
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              search_cache,
  input  logic [31:0]       address,
  input  logic [DATA_W-1:0] main_memory_data,
  output logic              hit,
  output logic              search_done,
  output logic [DATA_W-1:0] data,
  output logic [TAG_W-1:0]  tag_out,
`ifdef CACHE_STATS_EN
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count,
`endif
  output logic [1:0]        state,
  output logic [63:0]       RAM_address
);

  localparam int IDX_W = $clog2(NUM_LINES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic              valid_q [NUM_LINES];
  logic [TAG_W-1:0]  tag_q   [NUM_LINES];
  logic [DATA_W-1:0] line_q  [NUM_LINES];

  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] lat_tag;
  logic [IDX_W-1:0] lat_idx;
  logic             lookup_hit;
  logic             accept_hit;
  logic             accept_miss;
  logic             fill;

  // Bits above the tag carry no meaning for this cache.
  wire unused_addr = &{1'b0, address[31:TAG_W]};

  assign req_tag    = address[TAG_W-1:0];
  assign req_idx    = address[IDX_W-1:0];
  assign lat_idx    = lat_tag[IDX_W-1:0];
  assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign state      = state_q;

  // Request protocol: search_cache is a one-cycle request with no ready signal.
  // It is accepted only on an edge where state is IDLE; otherwise it is dropped.
  // search_done=1 means data/tag_out/hit describe the last accepted request.

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (search_cache && !lookup_hit) state_d = MEM_REQ;
      MEM_REQ:  state_d = MEM_WAIT;
      MEM_WAIT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    accept_hit  = 1'b0;
    accept_miss = 1'b0;
    fill        = 1'b0;
    case (state_q)
      IDLE: begin
        accept_hit  = search_cache && lookup_hit;
        accept_miss = search_cache && !lookup_hit;
      end
      MEM_WAIT: fill = 1'b1;
      default: ;
    endcase
  end

  // Reset warms the lower lines so bring-up can hit without memory traffic.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        if (i < PRELOAD_LINES) begin
          valid_q[i] <= 1'b1;
          tag_q[i]   <= TAG_W'(i);
          line_q[i]  <= DATA_W'(i) * DATA_W'(i);
        end else begin
          valid_q[i] <= 1'b0;
          tag_q[i]   <= '0;
          line_q[i]  <= '0;
        end
      end
    end else if (fill) begin
      valid_q[lat_idx] <= 1'b1;
      tag_q[lat_idx]   <= lat_tag;
      line_q[lat_idx]  <= main_memory_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit         <= 1'b0;
      search_done <= 1'b0;
      data        <= '0;
      tag_out     <= '0;
      RAM_address <= '0;
      lat_tag     <= '0;
    end else if (accept_hit) begin
      lat_tag     <= req_tag;
      data        <= line_q[req_idx];
      tag_out     <= req_tag;
      hit         <= 1'b1;
      search_done <= 1'b1;
    end else if (accept_miss) begin
      lat_tag     <= req_tag;
      RAM_address <= 64'(req_tag);
      hit         <= 1'b0;
      search_done <= 1'b0;
    end else if (fill) begin
      data        <= main_memory_data;
      tag_out     <= lat_tag;
      hit         <= 1'b0;
      search_done <= 1'b1;
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (accept_hit && (hit_count != 32'hFFFF_FFFF))   hit_count  <= hit_count + 32'd1;
      if (accept_miss && (miss_count != 32'hFFFF_FFFF)) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_unit.sv
// Self-checking bench for cache_unit: directed bring-up cases plus randomized lookups
// compared against a line-level reference model and a memory model with RAM[i]=i*i.
module tb_cache_unit;

  localparam int NL = 1024;
  localparam int PL = 512;

  logic        clock;
  logic        reset;
  logic        search_cache;
  logic [31:0] address;
  logic [63:0] main_memory_data;
  logic        hit;
  logic        search_done;
  logic [63:0] data;
  logic [27:0] tag_out;
  logic [1:0]  state;
  logic [63:0] RAM_address;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  cache_unit dut (
    .clock            (clock),
    .reset            (reset),
    .search_cache     (search_cache),
    .address          (address),
    .main_memory_data (main_memory_data),
    .hit              (hit),
    .search_done      (search_done),
    .data             (data),
    .tag_out          (tag_out),
`ifdef CACHE_STATS_EN
    .hit_count        (hit_count),
    .miss_count       (miss_count),
`endif
    .state            (state),
    .RAM_address      (RAM_address)
  );

  // ---------------- clock / memory model ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Registered main memory: word i holds i*i, one cycle read latency.
  initial main_memory_data = '0;
  always @(posedge clock) main_memory_data <= RAM_address * RAM_address;

  // ---------------- reference model + scoreboard ----------------
  bit          m_valid [NL];
  logic [27:0] m_tag   [NL];
  logic [63:0] m_line  [NL];
  logic [63:0] exp_q[$];
  int          total;
  int          bad;
  int          exp_hits;
  int          exp_misses;
  logic [63:0] last_data;
  logic [27:0] last_tag;
  logic        last_hit;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NL; i++) begin
      m_valid[i] = (i < PL);
      m_tag[i]   = (i < PL) ? 28'(i) : 28'd0;
      m_line[i]  = (i < PL) ? 64'(i) * 64'(i) : 64'd0;
    end
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_hit"},  {63'd0, hit}, 64'd0);
    check_val({tag, "_done"}, {63'd0, search_done}, 64'd0);
    check_val({tag, "_data"}, data, 64'd0);
    check_val({tag, "_tag"},  {36'd0, tag_out}, 64'd0);
    check_val({tag, "_ram"},  RAM_address, 64'd0);
    check_val({tag, "_fsm"},  {62'd0, state}, 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset        = 1'b0;
    search_cache = 1'b0;
    #1;
    check_reset_outputs("rst");
    @(negedge clock);
    reset = 1'b1;
    model_reset();
  endtask

  // ---------------- driver ----------------
  task automatic lookup(input logic [31:0] a, input bit noise);
    logic [27:0] t;
    int          idx;
    bit          exp_hit;
    logic [63:0] exp_data;
    t       = a[27:0];
    idx     = int'(a[9:0]);
    exp_hit = m_valid[idx] && (m_tag[idx] == t);
    @(negedge clock);
    address      = a;
    search_cache = 1'b1;
    @(negedge clock);
    if (exp_hit || !noise) search_cache = 1'b0;
    else                   address = $urandom;
    if (exp_hit) begin
      exp_hits++;
      exp_q.push_back(m_line[idx]);
      check_val("hit_flag", {63'd0, hit}, 64'd1);
      check_val("hit_done", {63'd0, search_done}, 64'd1);
      check_val("hit_tag",  {36'd0, tag_out}, {36'd0, t});
      check_val("hit_fsm",  {62'd0, state}, 64'd0);
    end else begin
      exp_misses++;
      check_val("miss_done0", {63'd0, search_done}, 64'd0);
      check_val("miss_hit0",  {63'd0, hit}, 64'd0);
      check_val("miss_ram",   RAM_address, {36'd0, t});
      check_val("miss_fsm1",  {62'd0, state}, 64'd1);
      @(negedge clock);
      if (noise) address = $urandom;
      check_val("miss_fsm2",  {62'd0, state}, 64'd2);
      @(negedge clock);
      search_cache = 1'b0;
      exp_data    = 64'(t) * 64'(t);
      m_valid[idx] = 1'b1;
      m_tag[idx]   = t;
      m_line[idx]  = exp_data;
      exp_q.push_back(exp_data);
      check_val("miss_hit",  {63'd0, hit}, 64'd0);
      check_val("miss_done", {63'd0, search_done}, 64'd1);
      check_val("miss_tag",  {36'd0, tag_out}, {36'd0, t});
      check_val("miss_fsm",  {62'd0, state}, 64'd0);
    end
    if (exp_q.size() == 0) check_val("sb_empty", 64'd1, 64'd0);
    else begin
      last_data = exp_q.pop_front();
      check_val("data", data, last_data);
    end
    last_tag = t;
    last_hit = exp_hit;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] recent [8];

  initial begin
    total = 0; bad = 0; exp_hits = 0; exp_misses = 0;
    reset = 1'b0; search_cache = 1'b0; address = '0;
    last_data = '0; last_tag = '0; last_hit = 1'b0;
    for (int i = 0; i < 8; i++) recent[i] = 32'(i);
    model_reset();

    // Bring-up sequence.
    do_reset();
    lookup(32'd0, 1'b0);
    check_val("tp0_data", data, 64'd0);
    lookup(32'd255, 1'b0);
    check_val("tp255_data", data, 64'd65025);
    lookup(32'd511, 1'b0);
    check_val("tp511_data", data, 64'd261121);
    lookup(32'd1023, 1'b0);
    check_val("tp1023_data", data, 64'd1046529);
    lookup(32'd1023, 1'b0);
    check_val("tp1023_rehit", {63'd0, hit}, 64'd1);
    lookup(32'd1536, 1'b1);
    lookup(32'd512, 1'b0);
    check_val("tp512_data", data, 64'd262144);
    lookup(32'd1536, 1'b0);

    // Outputs hold while idle.
    repeat (3) @(negedge clock);
    check_val("hold_data", data, last_data);
    check_val("hold_tag",  {36'd0, tag_out}, {36'd0, last_tag});
    check_val("hold_done", {63'd0, search_done}, 64'd1);

    // Reset during MEM_WAIT aborts the fill.
    do_reset();
    @(negedge clock);
    address = 32'd1023; search_cache = 1'b1;
    @(negedge clock);
    search_cache = 1'b0;
    @(negedge clock);
    check_val("abort_fsm_wait", {62'd0, state}, 64'd2);
    reset = 1'b0;
    #1;
    check_reset_outputs("abort");
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    exp_hits = 0; exp_misses = 0;
    lookup(32'd1023, 1'b0);
    check_val("abort_remiss", {63'd0, hit}, 64'd0);

    // Randomized lookups.
    for (int n = 0; n < 80; n++) begin
      logic [31:0] a;
      case ($urandom_range(0, 3))
        0:       a = {4'($urandom), 28'($urandom_range(0, PL - 1))};
        1:       a = 32'($urandom_range(0, 2047));
        2:       a = $urandom;
        default: a = recent[$urandom_range(0, 7)];
      endcase
      recent[n % 8] = a;
      lookup(a, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clock);
        check_val("rhold_data", data, last_data);
        check_val("rhold_hit",  {63'd0, hit}, {63'd0, last_hit});
      end
    end

`ifdef CACHE_STATS_EN
    check_val("hit_count",  {32'd0, hit_count},  64'(exp_hits));
    check_val("miss_count", {32'd0, miss_count}, 64'(exp_misses));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_unit.md
Name: cache_unit

Overview:
- Direct-mapped, read-only lookup cache between a requester and a one-cycle-latency main memory.
- Each line holds a 28-bit tag and one 64-bit data word. A line is architecturally 4 words but is treated as one 64-bit word.
- On a hit it returns the cached word. On a miss it fetches the word from main memory, fills the line and returns the word.
- Reset preloads ("warms") the lower lines with known contents so downstream blocks can be bring-up tested without memory traffic.

Parameters:
- NUM_LINES, 1024, number of cache lines; index = tag[9:0]; must be a power of 2.
- PRELOAD_LINES, 512, lines 0..PRELOAD_LINES-1 are valid after reset.
- DATA_W, 64, data word width.
- TAG_W, 28, tag width.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- search_cache  in  1  lookup request, sampled on the rising edge.
- address  in  32  lookup address; tag = address[27:0]; address[31:28] ignored.
- main_memory_data  in  64  read data from main memory, valid one cycle after RAM_address.
- hit  out  1  1 = last completed lookup hit.
- search_done  out  1  last lookup complete; data, tag_out and hit valid.
- data  out  64  word returned for the last completed lookup.
- tag_out  out  28  tag of the last completed lookup.
- RAM_address  out  64  main-memory word address, zero-extended tag.

Behaviour:
- Reset values (while reset=0):
  - hit=0, search_done=0, data=0, tag_out=0, RAM_address=0; FSM=IDLE.
  - For i < PRELOAD_LINES: valid[i]=1, tag[i]=i, line[i]=i*i (64-bit).
  - All other lines: valid=0, tag=0, line=0.
  - Reset mid-miss aborts the fill; the line is left as reinitialised.
- Lookup: idx = address[9:0], t = address[27:0]; hit when valid[idx] and tag[idx]==t.
- FSM states: IDLE, MEM_REQ, MEM_WAIT.
- IDLE, edge with search_cache=1:
  - Latch t.
  - On hit: data<=line[idx], tag_out<=t, hit<=1, search_done<=1; stay IDLE. Hit latency = 1 edge.
  - On miss: RAM_address<={36'b0,t}, hit<=0, search_done<=0; go MEM_REQ.
- MEM_REQ: memory registers RAM[RAM_address] on this edge; go MEM_WAIT.
- MEM_WAIT:
  - line[idx]<=main_memory_data, tag[idx]<=t, valid[idx]<=1.
  - data<=main_memory_data, tag_out<=t, hit<=0, search_done<=1; go IDLE.
  - Miss latency = 3 edges from the sampling edge.
  - hit stays 0 for the completed miss; a repeat lookup of the same tag then hits.
- search_cache outside IDLE is ignored; the request is dropped, not queued.
- Accepting a new request in IDLE clears search_done in the same edge for a miss. For a hit, search_done stays 1 and the outputs update.
- data, tag_out, hit and search_done hold their values until the next accepted request.
- A miss to an index holding a valid different tag overwrites that line (no write-back; cache is read-only).
- RAM_address holds its last value between misses.

Optional Feature:
- Macro CACHE_STATS_EN.
- Defined: adds outputs hit_count[31:0] and miss_count[31:0].
  - Both reset to 0.
  - hit_count increments on each accepted hit; miss_count on each accepted miss.
  - Both saturate at 32'hFFFFFFFF.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset: pulse reset low for 1 cycle -> all outputs 0. Then search address=0 -> hit=1, tag_out=0, data=0, search_done=1 one edge after the request.
- Search address=255 -> hit=1, tag_out=255, data=65025 after 1 edge.
- Search address=511 -> hit=1, tag_out=511, data=261121.
- Search address=1023 with memory RAM[i]=i*i -> RAM_address=1023.
  - After 3 edges: hit=0, search_done=1, data=1046529, tag_out=1023.
  - Repeat the search -> hit=1 after 1 edge.
- Search address=1536 (idx 512, invalid) -> miss fill. Then search address=512 (same idx, tag differs) -> miss, line replaced, data=262144.
- Assert reset during MEM_WAIT of a miss -> outputs 0, FSM IDLE. Line 1023 stays invalid: a subsequent search of 1023 misses again.
